i2c_xfer_engine: RTL

I2C_XFER_ENGINE -- requirements
Module: i2c_xfer_engine

---
 rtl/i2c_xfer_engine.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_xfer_engine.sv
// I2C transfer engine: sequences address/data/stop byte commands to a byte controller, with TX/RX FIFOs.
// Optional macro I2C_XFER_RESTART_EN adds RdLen for write-then-read via repeated start.
module i2c_xfer_engine #(
    parameter int DEPTH  = 8,
    parameter int LWIDTH = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Go,
    input  logic [6:0]        SlvAddr,
    input  logic              Rnw,
    input  logic [LWIDTH-1:0] Len,
`ifdef I2C_XFER_RESTART_EN
    input  logic [LWIDTH-1:0] RdLen,
`endif
    input  logic              TxWr,
    input  logic [7:0]        TxData,
    output logic              TxFull,
    input  logic              RxRd,
    output logic [7:0]        RxData,
    output logic              RxEmpty,
    output logic              Busy,
    output logic              Done,
    output logic              Nack,
    output logic              Al,
    output logic              Start,
    output logic              Stop,
    output logic              Read,
    output logic              Write,
    output logic              Tx_ack,
    output logic [7:0]        Tx_data,
    input  logic              Rx_ack,
    input  logic [7:0]        Rx_data,
    input  logic              I2C_done,
    input  logic              I2C_al
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, FIN} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, nack_q, nack_d, al_q, al_d;
    logic              start_q, start_d, stop_q, stop_d, read_q, read_d, write_q, write_d;
    logic              tx_ack_q, tx_ack_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [6:0]        addr_q, addr_d;
    logic              rnw_q, rnw_d, rs_q, rs_d, stop_only_q, stop_only_d;
    logic [LWIDTH-1:0] len_q, len_d, rem_q, rem_d;
`ifdef I2C_XFER_RESTART_EN
    logic [LWIDTH-1:0] rdlen_q, rdlen_d;
`endif
    logic [AW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]        tx_mem_q [DEPTH];
    logic [7:0]        rx_mem_q [DEPTH];

    logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop;
    logic outstanding, last, restart, al_set, abort, done_ev;

    assign tx_full     = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty    = (tx_cnt_q == '0);
    assign rx_full     = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty    = (rx_cnt_q == '0);
    assign outstanding = start_q | stop_q | read_q | write_q;
    assign last        = (rem_q == LWIDTH'(1));
    assign al_set      = I2C_al && (state_q != IDLE);
    assign abort       = al_set && (state_q != FIN);
    // Arbitration loss wins over a simultaneous completion.
    assign done_ev     = I2C_done && outstanding && !abort;
`ifdef I2C_XFER_RESTART_EN
    assign restart     = !rnw_q && (rdlen_q != '0);
`else
    assign restart     = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;   busy_q <= 1'b0;  done_q <= 1'b0;  nack_q <= 1'b0;  al_q <= 1'b0;
            start_q <= 1'b0;   stop_q <= 1'b0;  read_q <= 1'b0;  write_q <= 1'b0;
            tx_ack_q <= 1'b0;  tx_data_q <= 8'h00;
            addr_q <= '0;      rnw_q <= 1'b0;   rs_q <= 1'b0;    stop_only_q <= 1'b0;
            len_q <= '0;       rem_q <= '0;
`ifdef I2C_XFER_RESTART_EN
            rdlen_q <= '0;
`endif
            tx_wp_q <= '0;     tx_rp_q <= '0;   tx_cnt_q <= '0;
            rx_wp_q <= '0;     rx_rp_q <= '0;   rx_cnt_q <= '0;
        end else begin
            state_q <= state_d; busy_q <= busy_d; done_q <= done_d; nack_q <= nack_d; al_q <= al_d;
            start_q <= start_d; stop_q <= stop_d; read_q <= read_d; write_q <= write_d;
            tx_ack_q <= tx_ack_d; tx_data_q <= tx_data_d;
            addr_q <= addr_d;   rnw_q <= rnw_d;   rs_q <= rs_d;     stop_only_q <= stop_only_d;
            len_q <= len_d;     rem_q <= rem_d;
`ifdef I2C_XFER_RESTART_EN
            rdlen_q <= rdlen_d;
`endif
            tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; tx_cnt_q <= tx_cnt_d;
            rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d; rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= TxData;
        if (rx_push) rx_mem_q[rx_wp_q] <= Rx_data;
    end

    always_comb begin
        tx_push  = TxWr && !tx_full;
        rx_pop   = RxRd && !rx_empty;
        tx_wp_d  = tx_wp_q + AW'(tx_push);
        tx_rp_d  = tx_rp_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_wp_d  = rx_wp_q + AW'(rx_push);
        rx_rp_d  = rx_rp_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (Go && !busy_q) state_d = ADDR;
            ADDR:  if (done_ev) begin
                       if (len_q == '0)       state_d = FIN;
                       else if (Rx_ack)       state_d = WDATA;
                       else if (rs_q | rnw_q) state_d = RDATA;
                       else                   state_d = WDATA;
                   end
            WDATA: if (done_ev) begin
                       if (stop_only_q) state_d = FIN;
                       else if (last)   state_d = (restart && !Rx_ack) ? ADDR : FIN;
                   end
            RDATA: if (done_ev && last) state_d = FIN;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = FIN;
    end

    always_comb begin
        busy_d = busy_q;  done_d = 1'b0;  nack_d = nack_q;  al_d = al_q;
        start_d = start_q; stop_d = stop_q; read_d = read_q; write_d = write_q;
        tx_ack_d = tx_ack_q; tx_data_d = tx_data_q;
        addr_d = addr_q;  rnw_d = rnw_q;  rs_d = rs_q;  stop_only_d = stop_only_q;
        len_d = len_q;    rem_d = rem_q;
`ifdef I2C_XFER_RESTART_EN
        rdlen_d = rdlen_q;
`endif
        tx_pop = 1'b0;    rx_push = 1'b0;
        unique case (state_q)
            IDLE: if (Go && !busy_q) begin
                addr_d = SlvAddr; rnw_d = Rnw; len_d = Len; rem_d = Len;
`ifdef I2C_XFER_RESTART_EN
                rdlen_d = RdLen;
`endif
                nack_d = 1'b0; al_d = 1'b0; busy_d = 1'b1; rs_d = 1'b0; stop_only_d = 1'b0;
            end
            ADDR: if (!outstanding) begin
                start_d = 1'b1; write_d = 1'b1; stop_d = (len_q == '0);
                tx_data_d = {addr_q, rs_q | rnw_q};
            end else if (done_ev) begin
                // An address NACK with data pending still needs a Stop to release the bus.
                if (Rx_ack) begin nack_d = 1'b1; stop_only_d = (len_q != '0); end
`ifdef I2C_XFER_RESTART_EN
                if (rs_q) rem_d = rdlen_q;
`endif
                rs_d = 1'b0;
            end
            WDATA: if (!outstanding) begin
                if (stop_only_q) stop_d = 1'b1;
                else if (!tx_empty) begin
                    write_d = 1'b1; tx_data_d = tx_mem_q[tx_rp_q]; stop_d = last && !restart;
                end
            end else if (done_ev && !stop_only_q) begin
                tx_pop = 1'b1; rem_d = rem_q - LWIDTH'(1);
                if (Rx_ack) begin nack_d = 1'b1; stop_only_d = !last; end
                else if (last && restart) rs_d = 1'b1;
            end
            RDATA: if (!outstanding) begin
                if (!rx_full) begin read_d = 1'b1; tx_ack_d = last; stop_d = last; end
            end else if (done_ev) begin
                rx_push = 1'b1; rem_d = rem_q - LWIDTH'(1);
            end
            FIN: begin done_d = 1'b1; busy_d = 1'b0; rs_d = 1'b0; stop_only_d = 1'b0; end
            default: ;
        endcase
        if (done_ev || abort) begin
            start_d = 1'b0; stop_d = 1'b0; read_d = 1'b0; write_d = 1'b0; tx_ack_d = 1'b0;
        end
        if (al_set) al_d = 1'b1;
    end

    assign TxFull  = tx_full;
    assign RxEmpty = rx_empty;
    assign RxData  = rx_mem_q[rx_rp_q];
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Nack    = nack_q;
    assign Al      = al_q;
    assign Start   = start_q;
    assign Stop    = stop_q;
    assign Read    = read_q;
    assign Write   = write_q;
    assign Tx_ack  = tx_ack_q;
    assign Tx_data = tx_data_q;
endmodule
